dma_bus_arbiter: RTL and testbench
==================================

# dma_bus_arbiter

Round-robin arbiter that shares the single system bus between up to NR_MASTERS bus masters: ramDmaCi DMA instances, the CPU data port and other accelerators. It takes their requestTransaction lines, issues exactly one one-hot transactionGranted, and holds that grant until the owner's bus transaction ends. It sits between the masters and the bus multiplexer; its grantedId output also drives the bus-mux select.

## Interface
- NR_MASTERS, 4: number of requesters, 2..16.
- TIMEOUT_CYCLES, 256: ownership watchdog limit. Used only when the watchdog is compiled in.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- requestTransaction  input  NR_MASTERS  one bit per master; a bit stays high until that master is granted.
- transactionGranted  output  NR_MASTERS  registered, one-hot or zero; reset value 0.
- grantedId  output  $clog2(NR_MASTERS)  index of the current or last owner; reset value 0.
- busBusy  output  1  high in GRANT and BUSY states; reset value 0.
- beginTransactionIn  input  1  start pulse from the bus.
- endTransactionIn  input  1  end pulse from the bus.
- busErrorIn  input  1  bus error pulse.
- timeoutError  output  1  one-cycle pulse when the watchdog forces a release; reset value 0.

## Operation
- States: IDLE, GRANT, BUSY, RELEASE.
- Round-robin pointer rrPtr, reset value 0.
  - Winner = first set request bit scanning from rrPtr upward, wrapping from NR_MASTERS-1 to 0.
- IDLE, or RELEASE with any request set:
  - Go to GRANT.
  - Set transactionGranted[winner] and grantedId = winner.
- IDLE or RELEASE with no request: go to / stay in IDLE; grant stays 0.
- GRANT:
  - beginTransactionIn → BUSY.
  - beginTransactionIn and endTransactionIn in the same cycle (single-beat transfer) → RELEASE.
  - Owner drops its request bit before begin → RELEASE (abandoned grant).
- BUSY:
  - endTransactionIn or busErrorIn → RELEASE. If both arrive in the same cycle, handled as one release.
  - The owner dropping its request in BUSY is ignored; only end, error or timeout releases the bus.
- On every transition into RELEASE:
  - transactionGranted ← 0.
  - rrPtr ← (grantedId+1) mod NR_MASTERS.
  - grantedId is held.
- Requests that arrive while the bus is owned wait. There is no pre-emption.
- Fairness: a master that keeps requesting waits at most NR_MASTERS-1 other tenures.

## Timing
- Request high in cycle n while IDLE → grant visible in cycle n+1.
- endTransactionIn in cycle m → grant low in m+1 (RELEASE). The next winner's grant is visible in m+2.
- There is exactly one dead cycle between owners (bus turnaround). Two grant bits are never high at once.
- busBusy equals (state==GRANT or state==BUSY), registered in step with the grant.
- Reset asserted at any time:
  - All outputs go to their reset values immediately (asynchronous).
  - State returns to IDLE and rrPtr to 0.
  - An in-flight transaction is abandoned.
- Single-master requests at NR_MASTERS-1 wrap rrPtr to 0.

## Configuration
- ARBITER_TIMEOUT_EN defined:
  - A counter clears on entry to GRANT and increments every cycle in GRANT or BUSY.
  - When it reaches TIMEOUT_CYCLES-1 without a release: force RELEASE, pulse timeoutError for one cycle, advance rrPtr as for a normal release.
  - A normal release in the same cycle as the timeout takes priority; timeoutError does not pulse.
- ARBITER_TIMEOUT_EN undefined:
  - No counter is built; TIMEOUT_CYCLES is unused.
  - timeoutError is tied to 0.
  - A hung owner holds the bus until reset.

## Structure
- Shared package dma_bus_pkg holds:
  - the state enum (IDLE, GRANT, BUSY, RELEASE);
  - default constants for NR_MASTERS and TIMEOUT_CYCLES;
  - a function for the rotate-and-priority-encode winner selection, reused by future arbiters.
- One sub-module: arbiter_watchdog.
  - Holds the timeout counter with clear/enable inputs and an expire output.
  - Instantiated only under ARBITER_TIMEOUT_EN.

## Test plan
- Single master: request=0001 at cycle 1 → grant=0001 at cycle 2; begin at 4, end at 8 → grant=0000 at 9; rrPtr=1.
- Contention: request=1111 held, each master runs begin→end → grants appear in order 0001, 0010, 0100, 1000, 0001, with one zero cycle between each.
- Wrap and skip: rrPtr=3, request=0101 → grant=0001; after its end → grant=0100.
- Abandoned grant: master 2 is granted and drops its request before begin → RELEASE; the next requester is granted two cycles later; rrPtr=3.
- Error / simultaneous events: busErrorIn in BUSY → release identical to end. Begin and end in the same GRANT cycle → RELEASE directly.
- Watchdog (ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16): the owner never ends → grant drops 16 cycles after the grant and timeoutError pulses exactly once. Reset pulsed low mid-BUSY → grant=0 and busBusy=0 immediately, rrPtr=0.

Source files
------------

// File: rtl/dma_bus_pkg.sv
// Shared definitions for system-bus arbiters: FSM states, default sizing and
// the rotate-and-priority-encode winner search.
package dma_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_NR_MASTERS     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;
  localparam int MAX_MASTERS        = 16;
  localparam int MAX_ID_W           = 4;

  // Returns {found, index}: first set bit of req scanning upward from ptr,
  // wrapping at nr. Only the low nr bits of req take part.
  function automatic logic [MAX_ID_W:0] rr_select(
    input logic [MAX_MASTERS-1:0] req,
    input logic [MAX_ID_W-1:0]    ptr,
    input logic [MAX_ID_W:0]      nr
  );
    logic [MAX_ID_W:0] res;
    logic [MAX_ID_W:0] idx;
    res = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      idx = {1'b0, ptr} + (MAX_ID_W+1)'(i);
      if (idx >= nr) idx = idx - nr;
      if (((MAX_ID_W+1)'(i) < nr) && !res[MAX_ID_W] && req[idx[MAX_ID_W-1:0]])
        res = {1'b1, idx[MAX_ID_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_watchdog.sv
// Bus-ownership watchdog: counts cycles of one tenure and flags expiry at
// TIMEOUT_CYCLES-1. Only instantiated when ARBITER_TIMEOUT_EN is defined.
module arbiter_watchdog
  import dma_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;

  assign expire = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin system-bus arbiter with one dead cycle between owners.
// Optional ownership watchdog: define ARBITER_TIMEOUT_EN.
module dma_bus_arbiter
  import dma_bus_pkg::*;
#(
  parameter int NR_MASTERS     = DEF_NR_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NR_MASTERS-1:0]         requestTransaction,
  output logic [NR_MASTERS-1:0]         transactionGranted,
  output logic [$clog2(NR_MASTERS)-1:0] grantedId,
  output logic                          busBusy,
  input  logic                          beginTransactionIn,
  input  logic                          endTransactionIn,
  input  logic                          busErrorIn,
  output logic                          timeoutError
);

  localparam int ID_W = $clog2(NR_MASTERS);

  if (NR_MASTERS < 2 || NR_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("dma_bus_arbiter: NR_MASTERS must be 2..16 and TIMEOUT_CYCLES at least 2");
  end

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       next_ptr;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       id_d;
  logic [NR_MASTERS-1:0] grant_d;
  logic                  busy_d;
  logic [MAX_ID_W:0]     pick;
  logic                  any_req;
  logic                  owner_req;
  logic                  owned;
  logic                  normal_rel;
  logic                  wd_expire;

  assign pick      = rr_select(MAX_MASTERS'(requestTransaction), MAX_ID_W'(rr_ptr_q),
                               (MAX_ID_W+1)'(NR_MASTERS));
  assign any_req   = pick[MAX_ID_W];
  assign owner_req = requestTransaction[grantedId];
  assign owned     = (state_q == GRANT) || (state_q == BUSY);
  assign next_ptr  = (grantedId == ID_W'(NR_MASTERS - 1)) ? '0 : grantedId + ID_W'(1);

  always_comb begin
    winner = '0;
    for (int m = 0; m < NR_MASTERS; m++) begin
      if (pick[MAX_ID_W-1:0] == MAX_ID_W'(m)) winner = ID_W'(m);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = transactionGranted;
    id_d       = grantedId;
    busy_d     = busBusy;
    normal_rel = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        grant_d = '0;
        if (any_req) begin
          state_d         = GRANT;
          grant_d[winner] = 1'b1;
          id_d            = winner;
          busy_d          = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        // A begin in the same cycle as the owner dropping its request still counts.
        normal_rel = (beginTransactionIn && endTransactionIn) ||
                     (!beginTransactionIn && !owner_req);
        if (beginTransactionIn && !endTransactionIn) state_d = BUSY;
      end
      BUSY: begin
        normal_rel = endTransactionIn || busErrorIn;
      end
      default: ;
    endcase
    if (owned && (normal_rel || wd_expire)) begin
      state_d  = RELEASE;
      grant_d  = '0;
      busy_d   = 1'b0;
      rr_ptr_d = next_ptr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      rr_ptr_q           <= '0;
      transactionGranted <= '0;
      grantedId          <= '0;
      busBusy            <= 1'b0;
    end else begin
      state_q            <= state_d;
      rr_ptr_q           <= rr_ptr_d;
      transactionGranted <= grant_d;
      grantedId          <= id_d;
      busBusy            <= busy_d;
    end
  end

`ifdef ARBITER_TIMEOUT_EN
  logic wd_clear;
  logic timeout_fire;
  logic timeout_q;

  assign wd_clear     = ((state_q == IDLE) || (state_q == RELEASE)) && any_req;
  // A normal release in the expiry cycle wins; no error is reported then.
  assign timeout_fire = owned && wd_expire && !normal_rel;

  arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clear (wd_clear),
    .enable(owned),
    .expire(wd_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timeout_q <= 1'b0;
    else        timeout_q <= timeout_fire;
  end

  assign timeoutError = timeout_q;
`else
  assign wd_expire    = 1'b0;
  assign timeoutError = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: stimulus queues expected grants and
// timeout pulses, a negedge monitor pops and compares them as they appear.
module tb_dma_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] grant;
  logic [1:0]   gid;
  logic         busy;
  logic         begin_i = 1'b0;
  logic         end_i   = 1'b0;
  logic         err_i   = 1'b0;
  logic         tout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [1:0] id;
  } exp_t;

  exp_t gq[$];
  int   tq[$];
  exp_t mon_e;
  logic [N-1:0] prev_grant = '0;

  dma_bus_arbiter #(
    .NR_MASTERS    (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .requestTransaction(req),
    .transactionGranted(grant),
    .grantedId         (gid),
    .busBusy           (busy),
    .beginTransactionIn(begin_i),
    .endTransactionIn  (end_i),
    .busErrorIn        (err_i),
    .timeoutError      (tout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_grant(input int delay, input int idx);
    exp_t e;
    e.cyc   = cyc + delay;
    e.grant = 4'(1) << idx;
    e.id    = 2'(idx);
    gq.push_back(e);
  endtask

  // Entered in the owner's GRANT cycle; returns in the RELEASE cycle.
  // mode 0: end, 1: bus error, 2: end+error together, 3: single-beat begin+end.
  task automatic tenure(input int idx, input int nbusy, input int mode);
    if (mode == 3) begin
      begin_i = 1'b1; end_i = 1'b1;
      step(1);
      begin_i = 1'b0; end_i = 1'b0;
      req &= ~(4'(1) << idx);
    end else begin
      begin_i = 1'b1;
      step(1);
      begin_i = 1'b0;
      req &= ~(4'(1) << idx);
      chk("busy_in_tenure", 32'(busy), 32'(1));
      chk("grant_in_tenure", 32'(grant), 32'(4'(1) << idx));
      if (nbusy > 1) step(nbusy - 1);
      end_i = (mode != 1);
      err_i = (mode != 0);
      step(1);
      end_i = 1'b0; err_i = 1'b0;
    end
    chk("release_grant", 32'(grant), 32'(0));
    chk("release_busy", 32'(busy), 32'(0));
    chk("release_id_held", 32'(gid), 32'(idx));
  endtask

  always @(negedge clock) begin
    chk("onehot0", 32'($countones(grant) <= 1), 32'(1));
    if (grant != '0 && prev_grant == '0) begin
      if (gq.size() == 0) begin
        chk("unexpected_grant", 32'(grant), 32'(0));
      end else begin
        mon_e = gq.pop_front();
        chk("grant_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("grant_bits", 32'(grant), 32'(mon_e.grant));
        chk("grant_id", 32'(gid), 32'(mon_e.id));
        chk("grant_busy", 32'(busy), 32'(1));
      end
    end
    if (tout) begin
      if (tq.size() == 0) chk("unexpected_timeout", 32'(1), 32'(0));
      else                chk("timeout_cycle", 32'(cyc), 32'(tq.pop_front()));
    end
    prev_grant = grant;
  end

  int order[5] = '{1, 2, 3, 0, 1};
  int modes[5] = '{0, 1, 2, 3, 0};

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("reset_grant", 32'(grant), 32'(0));
    chk("reset_id", 32'(gid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_timeout", 32'(tout), 32'(0));
    step(2);
    reset = 1'b1;
    step(2);

    // single master
    req = 4'b0001; push_grant(1, 0); step(1);
    tenure(0, 4, 0);
    step(1);

    // contention, pointer now 1
    req = 4'b1111; push_grant(1, 1); step(1);
    for (int k = 0; k < 5; k++) begin
      tenure(order[k], 3, modes[k]);
      if (k < 4) begin
        req = 4'b1111;
        push_grant(1, order[k+1]);
      end else begin
        req = 4'b0000;
      end
      step(1);
    end

    // pointer 2: bring it to 3, then wrap and skip
    req = 4'b0100; push_grant(1, 2); step(1);
    tenure(2, 2, 0);
    step(1);
    req = 4'b0101; push_grant(1, 0); step(1);
    tenure(0, 2, 0);
    push_grant(1, 2); step(1);
    tenure(2, 2, 0);
    step(1);

    // error release of master 3 moves pointer to 0
    req = 4'b1000; push_grant(1, 3); step(1);
    tenure(3, 2, 1);
    step(1);

    // abandoned grant of master 2: pointer must become 3
    req = 4'b0100; push_grant(1, 2); step(1);
    req = 4'b1011; push_grant(2, 3); step(1);
    chk("abandon_grant", 32'(grant), 32'(0));
    chk("abandon_busy", 32'(busy), 32'(0));
    step(1);
    tenure(3, 1, 0);
    push_grant(1, 0); step(1);
    tenure(0, 1, 2);
    push_grant(1, 1); step(1);
    tenure(1, 1, 3);
    req = 4'b0000;
    step(1);

    // asynchronous reset mid-BUSY, pointer 2 before
    req = 4'b0100; push_grant(1, 2); step(1);
    begin_i = 1'b1; step(1);
    begin_i = 1'b0; req = 4'b0000;
    step(2);
    #2 reset = 1'b0;
    #1;
    chk("midreset_grant", 32'(grant), 32'(0));
    chk("midreset_busy", 32'(busy), 32'(0));
    chk("midreset_id", 32'(gid), 32'(0));
    step(1);
    reset = 1'b1;
    step(1);

    // pointer back at 0: 0110 must pick master 1; then owner hangs
    req = 4'b0110; push_grant(1, 1); step(1);
    begin_i = 1'b1; step(1);
    begin_i = 1'b0; req = 4'b0100;
`ifdef ARBITER_TIMEOUT_EN
    tq.push_back(cyc + 15);
    push_grant(16, 2);
    step(14);
    chk("wd_hold_grant", 32'(grant), 32'(4'b0010));
    step(1);
    chk("wd_release_grant", 32'(grant), 32'(0));
    chk("wd_release_busy", 32'(busy), 32'(0));
    step(1);
    tenure(2, 1, 0);
    step(1);
`else
    step(40);
    chk("hung_grant", 32'(grant), 32'(4'b0010));
    chk("hung_busy", 32'(busy), 32'(1));
    chk("hung_timeout", 32'(tout), 32'(0));
`endif

    step(3);
    chk("grant_queue_empty", 32'(gq.size()), 32'(0));
    chk("timeout_queue_empty", 32'(tq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
